// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: CPU MEM-stage port, loader/debug port and
// the single-ported synchronous memory port. The arbiter takes the slave
// view; the surrounding pipeline, loader and memory take the master view.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   // CPU MEM-stage port
   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   // loader / debug port
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_ack;
   logic [DATA_W-1:0] ld_rdata;

   // memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // status
   logic              err;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      input  mem_rdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      output ld_ack, ld_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output err
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      output ld_req, ld_we, ld_addr, ld_wdata,
      output mem_rdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      input  ld_ack, ld_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported synchronous data memory.
// The CPU normally wins; a pending loader is forced through after STARVE_LIM
// consecutive CPU wins. The grant decision and the memory port are purely
// combinational so a CPU access issues in the same cycle it is presented.
// Responses come back one cycle after issue, steered by per-requester
// pending flags.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   dmem_arbiter_if.slave bus
);

   localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

   // local copies of the bus inputs
   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign cpu_rd    = bus.cpu_rd;
   assign cpu_wr    = bus.cpu_wr;
   assign cpu_addr  = bus.cpu_addr;
   assign cpu_wdata = bus.cpu_wdata;
   assign ld_req    = bus.ld_req;
   assign ld_we     = bus.ld_we;
   assign ld_addr   = bus.ld_addr;
   assign ld_wdata  = bus.ld_wdata;
   assign mem_rdata = bus.mem_rdata;

   // state
   logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
   logic              ld_pend_reg;      // loader access issued last cycle (ack pending)
   logic              ld_rd_pend_reg;   // ...and it was a read
   logic              cpu_rd_pend_reg;  // CPU read issued last cycle
   logic [DATA_W-1:0] ld_rdata_reg;     // last loader read data, held between reads
   logic              err_reg;

   // grant decision
   logic cpu_req;
   logic ld_elig;
   logic ld_grant;
   logic cpu_grant;
   logic starved;

   // Arbitration: CPU by default, loader when the CPU is idle or the loader
   // has been starved long enough. Everything is gated by reset_n so the
   // memory port is quiet for the whole time reset is held.
   always_comb begin
      cpu_req   = cpu_rd | cpu_wr;
      ld_elig   = ld_req & ~ld_pend_reg;
      starved   = (starve_cnt_reg == LIM_C);
      ld_grant  = reset_n & ld_elig & (~cpu_req | starved);
      cpu_grant = reset_n & cpu_req & ~ld_grant;
   end

   // Memory port mux: driven straight from whichever requester won. A
   // simultaneous rd+wr from the CPU is issued as a write.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (cpu_grant) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = cpu_wr;
         bus.mem_addr  = cpu_addr;
         bus.mem_wdata = cpu_wdata;
      end else if (ld_grant) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = ld_we;
         bus.mem_addr  = ld_addr;
         bus.mem_wdata = ld_wdata;
      end
   end

   // Requester-side outputs. Read data is taken directly from the memory in
   // the response cycle; the loader's copy falls back to the held register
   // outside its read-ack cycle.
   always_comb begin
      bus.cpu_stall  = cpu_req & ld_grant;
      bus.cpu_rvalid = cpu_rd_pend_reg;
      bus.cpu_rdata  = cpu_rd_pend_reg ? mem_rdata : '0;
      bus.ld_ack     = ld_pend_reg;
      bus.ld_rdata   = (ld_pend_reg & ld_rd_pend_reg) ? mem_rdata : ld_rdata_reg;
      bus.err        = err_reg;
   end

   // Starvation counter: counts CPU wins over an eligible loader, saturating
   // at the limit; cleared once the loader is served or withdraws.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!ld_req || ld_grant) begin
         starve_cnt_next = '0;
      end else if (cpu_grant && ld_elig && !starved) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   // Arbitration state and response-pending flags; async reset drops any
   // in-flight response so nothing is reported after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_reg  <= '0;
         ld_pend_reg     <= 1'b0;
         ld_rd_pend_reg  <= 1'b0;
         cpu_rd_pend_reg <= 1'b0;
      end else begin
         starve_cnt_reg  <= starve_cnt_next;
         ld_pend_reg     <= ld_grant;
         ld_rd_pend_reg  <= ld_grant & ~ld_we;
         cpu_rd_pend_reg <= cpu_grant & ~cpu_wr;
      end
   end

   // Hold the last loader read result so ld_rdata stays stable between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_rdata_reg <= '0;
      end else if (ld_pend_reg && ld_rd_pend_reg) begin
         ld_rdata_reg <= mem_rdata;
      end
   end

   // Sticky protocol error: CPU asserted load and store together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_reg <= 1'b0;
      end else if (cpu_rd && cpu_wr) begin
         err_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: an independent cycle model predicts
// the grant of every cycle; read responses are queued at issue time and
// popped when the arbiter reports rvalid / ld_ack.
module tb_dmem_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int LIM    = 3;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } resp_t;

   logic clk;
   logic reset_n;

   dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(LIM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory behaviour: synchronous read, write on enable
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference model state
   int          m_cnt;
   logic        m_ldpend;
   logic        m_rdpend;
   logic        m_err;
   logic [31:0] m_hold;
   resp_t       cpu_q[$];
   resp_t       ld_q[$];

   logic ld_done;
   logic last_stall;

   task automatic model_reset();
      m_cnt = 0; m_ldpend = 0; m_rdpend = 0; m_err = 0; m_hold = '0;
      cpu_q.delete(); ld_q.delete();
   endtask

   // one clock cycle: check at negedge, advance the model, return #1 after posedge
   task automatic step();
      logic  cpu_req, elig, lg, cg, e_we;
      logic [31:0] e_addr, e_wdata;
      resp_t r;
      @(negedge clk);
      cpu_req = bus.cpu_rd | bus.cpu_wr;
      elig    = bus.ld_req & ~m_ldpend;
      lg      = reset_n & elig & (~cpu_req | (m_cnt == LIM));
      cg      = reset_n & cpu_req & ~lg;
      e_we    = cg ? bus.cpu_wr : (lg ? bus.ld_we : 1'b0);
      e_addr  = cg ? bus.cpu_addr : (lg ? bus.ld_addr : 32'h0);
      e_wdata = cg ? bus.cpu_wdata : (lg ? bus.ld_wdata : 32'h0);
      last_stall = bus.cpu_stall;

      check_val("mem_en", bus.mem_en, cg | lg);
      check_val("mem_we", bus.mem_we, e_we);
      if (cg || lg || !reset_n) begin
         check_val("mem_addr", bus.mem_addr, e_addr);
         check_val("mem_wdata", bus.mem_wdata, e_wdata);
      end
      check_val("cpu_stall", bus.cpu_stall, cpu_req & lg);
      check_val("err", bus.err, m_err);

      check_val("cpu_rvalid", bus.cpu_rvalid, m_rdpend);
      if (m_rdpend) begin
         if (cpu_q.size() == 0) check_val("cpu_q_underflow", 1, 0);
         else begin
            r = cpu_q.pop_front();
            check_val("cpu_rdata", bus.cpu_rdata, r.data);
            $display("cpu read resp data=%08h exp=%08h", bus.cpu_rdata, r.data);
         end
      end else if (!reset_n) begin
         check_val("cpu_rdata_rst", bus.cpu_rdata, 0);
      end

      check_val("ld_ack", bus.ld_ack, m_ldpend);
      if (m_ldpend) begin
         ld_done = 1'b1;
         if (ld_q.size() == 0) check_val("ld_q_underflow", 1, 0);
         else begin
            r = ld_q.pop_front();
            if (r.is_read) m_hold = r.data;
            $display("loader %s ack rdata=%08h exp=%08h", r.is_read ? "read" : "write", bus.ld_rdata, m_hold);
         end
      end
      check_val("ld_rdata", bus.ld_rdata, m_hold);

      // advance model
      if (cg && !bus.cpu_wr) begin
         r.is_read = 1'b1; r.data = mem[bus.cpu_addr[9:2]];
         cpu_q.push_back(r);
      end
      if (lg) begin
         r.is_read = ~bus.ld_we; r.data = mem[bus.ld_addr[9:2]];
         ld_q.push_back(r);
      end
      if (reset_n) begin
         if (!bus.ld_req || lg)              m_cnt = 0;
         else if (cg && elig && m_cnt < LIM) m_cnt = m_cnt + 1;
         m_ldpend = lg;
         m_rdpend = cg & ~bus.cpu_wr;
         if (bus.cpu_rd && bus.cpu_wr) m_err = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic loader_start(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d; ld_done = 1'b0;
   endtask

   int stall_cyc;
   int stall_cnt;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[8'h04] = 32'hDEAD_BEEF;
      bus.mem_rdata = '0;
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0);  // request held during reset must not issue
      bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
      ld_done = 1'b1; last_stall = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      step();
      step();
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b1;   // released #1 after a rising edge

      // lone CPU read, issued on the first edge after release
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
      step();
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // loader write with no CPU traffic; ld_req held through the ack cycle
      loader_start(1'b1, 32'h40, 32'h55);
      step();
      check_val("ld_wr_ack_pending", ld_done, 0);
      step();
      check_val("ld_wr_acked", ld_done, 1);
      bus.ld_req = 1'b0;
      step();

      // CPU busy every cycle plus a loader read: loader forced on cycle LIM+1
      loader_start(1'b0, 32'h40, 32'h0);
      stall_cyc = 0; stall_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         if (ld_done) bus.ld_req = 1'b0;
         cpu_set(c[0], ~c[0], 32'h80 + 32'(c) * 4, $urandom);
         step();
         if (last_stall) begin
            stall_cnt++;
            if (stall_cyc == 0) stall_cyc = c;
         end
      end
      check_val("starve_grant_cycle", stall_cyc, LIM + 1);
      check_val("stall_cycles", stall_cnt, 1);
      check_val("starve_ld_acked", ld_done, 1);
      bus.ld_req = 1'b0;
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // simultaneous load+store: issued as write, sticky err
      cpu_set(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
      step();
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      check_val("err_sticky", bus.err, 1);

      // mixed random traffic
      for (int c = 0; c < 300; c++) begin
         if (ld_done && bus.ld_req) bus.ld_req = 1'b0;
         else if (!bus.ld_req && $urandom_range(0, 3) == 0)
            loader_start($urandom_range(0, 1), 32'($urandom_range(0, 63)) << 2, $urandom);
         case ($urandom_range(0, 3))
            0: cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
            1: cpu_set(1'b0, 1'b1, 32'($urandom_range(0, 63)) << 2, $urandom);
            default: cpu_set(1'b1, 1'b0, 32'($urandom_range(0, 63)) << 2, 32'h0);
         endcase
         step();
      end
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 0; c < 4 && bus.ld_req; c++) begin
         if (ld_done) bus.ld_req = 1'b0;
         step();
      end
      bus.ld_req = 1'b0;
      step();
      step();

      // reset while a CPU read response is in flight
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
      step();
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b0;
      model_reset();
      step();
      step();
      reset_n = 1'b1;
      step();
      check_val("err_cleared", bus.err, 0);
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
      step();
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check_val("cpu_q_drained", cpu_q.size(), 0);
      check_val("ld_q_drained", ld_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data width of the memory and both requesters.
REQ-002 The block SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-003 The block SHALL have parameter STARVE_LIM, default 3, the number of consecutive CPU wins against a pending loader before the loader is forced.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_rd  input  1  MEM-stage load request (readdmem).
REQ-007 cpu_wr  input  1  MEM-stage store request (writedmem).
REQ-008 cpu_addr  input  ADDR_W  CPU access address.
REQ-009 cpu_wdata  input  DATA_W  CPU store data.
REQ-010 cpu_stall  output  1  high while a CPU request is present and not issued this cycle; freezes the pipeline.
REQ-011 cpu_rdata  output  DATA_W  load data returned to the CPU.
REQ-012 cpu_rvalid  output  1  one-cycle pulse qualifying cpu_rdata.
REQ-013 ld_req  input  1  loader/debug request, held high until ld_ack.
REQ-014 ld_we  input  1  loader write (1) / read (0); stable while ld_req is high.
REQ-015 ld_addr  input  ADDR_W  loader address.
REQ-016 ld_wdata  input  DATA_W  loader write data.
REQ-017 ld_ack  output  1  one-cycle completion pulse; ld_rdata is valid with it for reads.
REQ-018 ld_rdata  output  DATA_W  loader read data.
REQ-019 mem_en, mem_we  output  1 each  memory access enable / write enable.
REQ-020 mem_addr, mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-021 mem_rdata  input  DATA_W  synchronous read data, valid the cycle after a read issue.
REQ-022 err  output  1  sticky flag: cpu_rd and cpu_wr both high in the same cycle.

Function
REQ-023 The block SHALL issue at most one memory access per cycle; mem_* SHALL be driven combinationally from the requester granted in that cycle; mem_en=0 when nobody is granted.
REQ-024 A CPU request SHALL be present when cpu_rd|cpu_wr; mem_we=cpu_wr; cpu_rd&cpu_wr SHALL issue as a write and set err.
REQ-025 A loader request SHALL be eligible when ld_req=1 and no loader access was issued in the previous cycle (ack-pending guard), preventing double issue.
REQ-026 Priority: CPU wins by default; the loader wins when eligible and starve_cnt==STARVE_LIM, or when no CPU request is present.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_LIM, on each cycle the CPU is granted while the loader is eligible; it SHALL clear when the loader is granted or ld_req=0.
REQ-028 cpu_stall = CPU request present AND loader granted this cycle; cpu_stall SHALL NOT depend on registered state beyond starve_cnt and the ack-pending flag.
REQ-029 A CPU read issued in cycle T SHALL produce cpu_rvalid=1 and cpu_rdata=mem_rdata in T+1; a CPU write produces no cpu_rvalid.
REQ-030 A loader access issued in cycle T SHALL produce ld_ack=1 in T+1, with ld_rdata=mem_rdata for reads; ld_rdata SHALL hold its value until the next loader read.
REQ-031 Back-to-back CPU accesses SHALL issue in consecutive cycles with no bubble.
REQ-032 Loader throughput SHALL be at most one access per two cycles due to REQ-025.
REQ-033 An in-flight response at the time reset_n falls SHALL be discarded; no rvalid or ack SHALL follow reset release.

Reset
REQ-034 While reset_n=0: cpu_stall, cpu_rvalid, ld_ack, mem_en, mem_we, err = 0; cpu_rdata, ld_rdata, mem_addr, mem_wdata = 0; starve_cnt and the ack-pending flag = 0.
REQ-035 The first access SHALL be issuable in the first clock edge after reset_n rises.

Verification
REQ-036 CPU read addr 0x10 alone, mem returns 0xDEADBEEF -> mem_en=1, mem_we=0 in T; cpu_rvalid=1, cpu_rdata=0xDEADBEEF in T+1; cpu_stall=0 throughout.
REQ-037 Loader write addr 0x40, data 0x55 with no CPU traffic -> mem_we=1 in T; ld_ack=1 in T+1; no re-issue in T+1 with ld_req still high.
REQ-038 CPU requests every cycle plus a loader read, STARVE_LIM=3 -> CPU granted 3 cycles, loader granted in the 4th with cpu_stall=1 for exactly that cycle, ld_ack next cycle.
REQ-039 cpu_rd=cpu_wr=1 -> write issued, err=1 and remains 1 until reset.
REQ-040 reset_n asserted in the cycle after a CPU read issue -> no cpu_rvalid pulse; all outputs 0; normal operation on release.
